// File: rtl/alu_pkg.sv
// Shared types and constants for the serial subtractor.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// Handshake: start is accepted only while busy=0 (IDLE or DONE) and ignored otherwise; done pulses one cycle with y/bout/ovf valid.
interface serial_subtractor_if
  import alu_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, y, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, y, bout, ovf
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per cycle through a single full_subtractor cell.
// Optional signed overflow flag enabled by macro SERIAL_SUBTRACTOR_OVF_EN (ovf tied to 0 otherwise).
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus,
  output sub_state_t         o_state
);
  localparam int CW = $clog2(WIDTH + 1);

  sub_state_t       r_state;
  sub_state_t       w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_y;
  logic             r_br;
  logic             r_bout;
  logic             r_done;
  logic             w_d;
  logic             w_bout;
  logic             w_launch;
  logic             w_last_bit;

  full_subtractor u_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // DONE accepts a new request so back-to-back operations need no idle cycle.
  assign w_launch   = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next_state = SHIFT;
      SHIFT:   if (w_last_bit) w_next_state = DONE;
      DONE:    w_next_state = bus.start ? SHIFT : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_res   <= '0;
      r_y     <= '0;
      r_bout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_launch) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_br  <= bus.bin;
        r_cnt <= '0;
      end else if (r_state == SHIFT) begin
        // Operands shift right so the cell always sees bit 0; difference fills from the top.
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_bout;
        r_res <= {w_d, r_res[WIDTH-1:1]};
        r_cnt <= r_cnt + CW'(1);
      end
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_y    <= r_res;
        r_bout <= r_br;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Operand sign bits are kept aside because the operand registers are consumed by shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_launch) begin
        r_a_msb <= bus.a[WIDTH-1];
        r_b_msb <= bus.b[WIDTH-1];
      end
      if (r_state == DONE) r_ovf <= (r_a_msb != r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy = (r_state == SHIFT);
  assign bus.done = r_done;
  assign bus.y    = r_y;
  assign bus.bout = r_bout;
  assign o_state  = r_state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): vector table, corner sequences, random ops.
module tb_serial_subtractor;
  import alu_pkg::*;

  localparam int W = 4;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] y;
    logic         bout;
    logic         ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  sub_state_t state;
  int         cyc = 0;
  int         t_launch = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_done = 0;
  logic [W+1:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(W)) s ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (s),
    .o_state (state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0]   diff;
    logic [W-1:0] y;
    logic         ovf;
    diff = {1'b0, a} - {1'b0, b} - (W + 1)'(bin);
    y    = diff[W-1:0];
    ovf  = OVF_ON && (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
    return {y, diff[W], ovf};
  endfunction

  // scoreboard: pop expected result on every done pulse
  always @(negedge clk) begin : scoreboard
    logic [W+1:0] e;
    if (s.done === 1'b1) begin
      n_done++;
      check("result_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("y", 64'(s.y), 64'(e[W+1:2]));
        check("bout", 64'(s.bout), 64'(e[1]));
        check("ovf", 64'(s.ovf), 64'(e[0]));
      end
    end
  end

  // driver tasks
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W+1:0] e);
    s.a      = a;
    s.b      = b;
    s.bin    = bin;
    s.start  = 1'b1;
    t_launch = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    s.start = 1'b0;
    s.a     = W'($urandom);
    s.b     = W'($urandom);
    s.bin   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n;
    n = 0;
    while (s.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 64'(s.done === 1'b1), 64'(1));
    check({name, "_latency"}, 64'(cyc - t_launch), 64'(exp_lat));
    @(negedge clk);
    check({name, "_single_pulse"}, 64'(s.done), 64'(0));
  endtask

  task automatic check_cleared(input string name);
    check({name, "_busy"}, 64'(s.busy), 64'(0));
    check({name, "_done"}, 64'(s.done), 64'(0));
    check({name, "_y"}, 64'(s.y), 64'(0));
    check({name, "_bout"}, 64'(s.bout), 64'(0));
    check({name, "_ovf"}, 64'(s.ovf), 64'(0));
    check({name, "_state"}, 64'(state), 64'(IDLE));
  endtask

  vec_t tbl[7];

  initial begin
    int d0;
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    tbl[0] = '{a: 4'b0000, b: 4'b0000, bin: 1'b0, y: 4'b0000, bout: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: 4'b0110, b: 4'b0001, bin: 1'b0, y: 4'b0101, bout: 1'b0, ovf: 1'b0};
    tbl[2] = '{a: 4'b0000, b: 4'b0001, bin: 1'b0, y: 4'b1111, bout: 1'b1, ovf: 1'b0};
    tbl[3] = '{a: 4'b0100, b: 4'b0110, bin: 1'b1, y: 4'b1101, bout: 1'b1, ovf: 1'b0};
    tbl[4] = '{a: 4'b0111, b: 4'b1000, bin: 1'b0, y: 4'b1111, bout: 1'b1, ovf: OVF_ON};
    tbl[5] = '{a: 4'b1000, b: 4'b0001, bin: 1'b0, y: 4'b0111, bout: 1'b0, ovf: OVF_ON};
    tbl[6] = '{a: 4'b1111, b: 4'b1111, bin: 1'b1, y: 4'b1111, bout: 1'b1, ovf: 1'b0};

    s.start = 1'b0;
    s.a     = '0;
    s.b     = '0;
    s.bin   = 1'b0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 7; i++) begin
      launch(tbl[i].a, tbl[i].b, tbl[i].bin, {tbl[i].y, tbl[i].bout, tbl[i].ovf});
      check("busy_in_shift", 64'(s.busy), 64'(1));
      wait_done("vec", 6);
      repeat (2) @(negedge clk);
      check("y_hold", 64'(s.y), 64'(tbl[i].y));
      check("bout_hold", 64'(s.bout), 64'(tbl[i].bout));
      check("idle_after", 64'(state), 64'(IDLE));
    end

    // start pulsed two cycles into SHIFT is ignored
    d0 = n_done;
    launch(4'b0110, 4'b0001, 1'b0, model(4'b0110, 4'b0001, 1'b0));
    @(negedge clk);
    s.start = 1'b1;
    s.a     = 4'b1111;
    s.b     = 4'b0000;
    @(negedge clk);
    s.start = 1'b0;
    wait_done("ignored_start", 6);
    repeat (10) @(negedge clk);
    check("ignored_start_one_done", 64'(n_done - d0), 64'(1));

    // back-to-back launch from DONE
    launch(4'b0100, 4'b0110, 1'b1, model(4'b0100, 4'b0110, 1'b1));
    n = 0;
    while (state != DONE && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_reached_done", 64'(state == DONE), 64'(1));
    launch(4'b0111, 4'b1000, 1'b0, model(4'b0111, 4'b1000, 1'b0));
    check("b2b_first_done", 64'(s.done), 64'(1));
    check("b2b_no_idle_busy", 64'(s.busy), 64'(1));
    @(negedge clk);
    wait_done("b2b_second", 6);

    // reset during the 3rd SHIFT cycle
    launch(4'b1000, 4'b0001, 1'b0, model(4'b1000, 4'b0001, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_cleared("mid_shift_reset");
    rst = 1'b0;
    d0 = n_done;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", 64'(n_done - d0), 64'(0));

    // reset wins over start in the same cycle
    rst     = 1'b1;
    s.start = 1'b1;
    s.a     = 4'b0101;
    s.b     = 4'b0011;
    @(negedge clk);
    rst     = 1'b0;
    s.start = 1'b0;
    check("rst_over_start_state", 64'(state), 64'(IDLE));
    check("rst_over_start_busy", 64'(s.busy), 64'(0));
    d0 = n_done;
    repeat (10) @(negedge clk);
    check("rst_over_start_no_done", 64'(n_done - d0), 64'(0));

    // random operations against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      ra   = W'($urandom_range(0, (1 << W) - 1));
      rb   = W'($urandom_range(0, (1 << W) - 1));
      rbin = 1'($urandom_range(0, 1));
      launch(ra, rb, rbin, model(ra, rb, rbin));
      wait_done("rand", 6);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
